// File: rtl/tt_sweep.sv
`default_nettype none
//============================================================================
// Module      : tt_sweep
// Description : Sequential truth-table engine. Latches an N_IN-input Boolean
//               function (minterm mask) plus an expected mask, then streams
//               every input row in ascending order over valid/ready. Each row
//               reports its output and whether it mismatches the expectation.
//               On completion done pulses with the final ones/mismatch counts.
// Ports       :
//   in_clk    - clock, rising edge
//   in_rst    - synchronous active-high reset
//   in_start  - start request (honoured in IDLE or DONE only)
//   in_func   - function mask, bit r = Y for row r
//   in_ref    - expected mask, same encoding
//   in_ready  - downstream accepts the current row
//   out_valid - row data valid (RUN)
//   out_row   - current row index
//   out_y     - function value of current row
//   out_mis   - function XOR expected for current row
//   out_busy  - high while streaming
//   out_done  - one-cycle completion pulse
//   out_ones  - running/final count of accepted rows with Y=1
//   out_errs  - running/final count of accepted rows with mismatch
// Revision    : 1.0 - initial release
//============================================================================
module tt_sweep #(
    parameter int N_IN = 3
) (
    input  logic                   in_clk,
    input  logic                   in_rst,
    input  logic                   in_start,
    input  logic [(1<<N_IN)-1:0]   in_func,
    input  logic [(1<<N_IN)-1:0]   in_ref,
    input  logic                   in_ready,
    output logic                   out_valid,
    output logic [N_IN-1:0]        out_row,
    output logic                   out_y,
    output logic                   out_mis,
    output logic                   out_busy,
    output logic                   out_done,
    output logic [N_IN:0]          out_ones,
    output logic [N_IN:0]          out_errs
);

    localparam int ROWS = 1 << N_IN;

    localparam logic [N_IN-1:0] c_LAST_ROW = {N_IN{1'b1}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [ROWS-1:0] r_func;
    logic [ROWS-1:0] r_ref;
    logic [N_IN-1:0] r_row;
    logic [N_IN:0]   r_ones;
    logic [N_IN:0]   r_errs;

    logic w_run;
    logic w_y;
    logic w_mis;

    assign w_run = (r_state == S_RUN);
    assign w_y   = r_func[r_row];
    assign w_mis = r_func[r_row] ^ r_ref[r_row];

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state <= S_IDLE;
            r_func  <= '0;
            r_ref   <= '0;
            r_row   <= '0;
            r_ones  <= '0;
            r_errs  <= '0;
        end else begin
            case (r_state)
                // DONE behaves like IDLE for start so a restart can follow
                // the completion pulse with no idle gap.
                S_IDLE, S_DONE: begin
                    if (in_start) begin
                        r_func  <= in_func;
                        r_ref   <= in_ref;
                        r_row   <= '0;
                        r_ones  <= '0;
                        r_errs  <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (in_ready) begin
                        r_ones <= r_ones + {{N_IN{1'b0}}, w_y};
                        r_errs <= r_errs + {{N_IN{1'b0}}, w_mis};
                        // Exit on the last row so the row counter never wraps.
                        if (r_row == c_LAST_ROW) begin
                            r_state <= S_DONE;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // All outputs are decoded from registers only; row data is gated by the
    // RUN state so it reads as zero whenever nothing is being presented.
    assign out_valid = w_run;
    assign out_busy  = w_run;
    assign out_done  = (r_state == S_DONE);
    assign out_row   = r_row;
    assign out_y     = w_run & w_y;
    assign out_mis   = w_run & w_mis;
    assign out_ones  = r_ones;
    assign out_errs  = r_errs;

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep.sv
`default_nettype none
//============================================================================
// Module      : tb_tt_sweep
// Description : Self-checking bench for tt_sweep. Stimulus pushes expected
//               rows and completion records into queues; a negedge monitor
//               pops and compares whenever the DUT presents data. Also runs
//               a parameter sweep on N_IN=1 and N_IN=8 instances.
// Revision    : 1.0 - initial release
//============================================================================
module tb_tt_sweep;

    typedef struct {
        int row;
        bit y;
        bit mis;
    } row_t;

    typedef struct {
        int edge_n;
        int ones;
        int errs;
    } done_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int total = 0;
    int bad   = 0;

    row_t  exp_rows[$];
    done_t exp_done[$];
    int    last_ones = 0;
    int    last_errs = 0;

    // ---------------- N_IN = 3 instance ----------------
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] func3 = '0;
    logic [7:0] ref3 = '0;
    logic       ready = 1'b0;
    logic       valid, y, mis, busy, done;
    logic [2:0] row;
    logic [3:0] ones, errs;

    tt_sweep #(.N_IN(3)) dut3 (
        .in_clk(clk), .in_rst(rst), .in_start(start), .in_func(func3),
        .in_ref(ref3), .in_ready(ready), .out_valid(valid), .out_row(row),
        .out_y(y), .out_mis(mis), .out_busy(busy), .out_done(done),
        .out_ones(ones), .out_errs(errs)
    );

    // ---------------- N_IN = 1 and 8 instances ----------------
    logic         s_start = 1'b0;
    logic [1:0]   f1 = '0;
    logic [1:0]   r1 = '0;
    logic [255:0] f8 = '0;
    logic [255:0] r8 = '0;
    logic         v1, y1, m1, b1, d1;
    logic [0:0]   row1;
    logic [1:0]   ones1, errs1;
    logic         v8, y8, m8, b8, d8;
    logic [7:0]   row8;
    logic [8:0]   ones8, errs8;

    tt_sweep #(.N_IN(1)) dut1 (
        .in_clk(clk), .in_rst(rst), .in_start(s_start), .in_func(f1),
        .in_ref(r1), .in_ready(1'b1), .out_valid(v1), .out_row(row1),
        .out_y(y1), .out_mis(m1), .out_busy(b1), .out_done(d1),
        .out_ones(ones1), .out_errs(errs1)
    );

    tt_sweep #(.N_IN(8)) dut8 (
        .in_clk(clk), .in_rst(rst), .in_start(s_start), .in_func(f8),
        .in_ref(r8), .in_ready(1'b1), .out_valid(v8), .out_row(row8),
        .out_y(y8), .out_mis(m8), .out_busy(b8), .out_done(d8),
        .out_ones(ones8), .out_errs(errs8)
    );

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (valid) begin
            if (exp_rows.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got row=%0d with no row expected", row);
            end else begin
                row_t e;
                e = exp_rows[0];
                total++;
                if (int'(row) != e.row || y != e.y || mis != e.mis || !busy || done) begin
                    bad++;
                    $display("FAIL row_check: got row=%0d y=%0b mis=%0b busy=%0b done=%0b, expected row=%0d y=%0b mis=%0b busy=1 done=0",
                             row, y, mis, busy, done, e.row, e.y, e.mis);
                end
                if (ready) void'(exp_rows.pop_front());
            end
        end
        if (done) begin
            total++;
            if (exp_done.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: done at edge %0d with none expected", edge_cnt);
            end else begin
                done_t d;
                d = exp_done.pop_front();
                if (edge_cnt != d.edge_n || int'(ones) != d.ones || int'(errs) != d.errs
                    || valid || busy) begin
                    bad++;
                    $display("FAIL done_check: got edge=%0d ones=%0d errs=%0d valid=%0b busy=%0b, expected edge=%0d ones=%0d errs=%0d valid=0 busy=0",
                             edge_cnt, ones, errs, valid, busy, d.edge_n, d.ones, d.errs);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_zero(input string name);
        @(negedge clk);
        total++;
        if ({valid, busy, done, row, y, mis, ones, errs} != '0) begin
            bad++;
            $display("FAIL %s: got valid=%0b busy=%0b done=%0b row=%0d y=%0b mis=%0b ones=%0d errs=%0d, expected all 0",
                     name, valid, busy, done, row, y, mis, ones, errs);
        end
    endtask

    task automatic check_hold(input string name);
        @(negedge clk);
        total++;
        if (int'(ones) != last_ones || int'(errs) != last_errs || valid || busy || done) begin
            bad++;
            $display("FAIL %s: got ones=%0d errs=%0d valid=%0b busy=%0b done=%0b, expected ones=%0d errs=%0d idle",
                     name, ones, errs, valid, busy, done, last_ones, last_errs);
        end
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode 0: ready always 1; mode 1: ready pattern 1,0,0,...; mode 2: random.
    // abort_row >= 0 resets the DUT while that row is being presented.
    task automatic run(input logic [7:0] fm, input logic [7:0] rm,
                       input int mode, input int abort_row);
        bit    pat[$];
        int    n_ok;
        int    k;
        row_t  e;
        done_t d;
        n_ok = 0;
        while (n_ok < 8) begin
            bit b;
            case (mode)
                0:       b = 1'b1;
                1:       b = (pat.size() % 3 == 0);
                default: b = 1'($urandom_range(0, 1));
            endcase
            pat.push_back(b);
            if (b) n_ok++;
        end
        k = edge_cnt + 1;
        for (int i = 0; i < 8; i++) begin
            e.row = i;
            e.y   = fm[i];
            e.mis = fm[i] ^ rm[i];
            exp_rows.push_back(e);
        end
        d.edge_n = k + pat.size();
        d.ones   = $countones(fm);
        d.errs   = $countones(fm ^ rm);
        exp_done.push_back(d);
        last_ones = d.ones;
        last_errs = d.errs;

        start = 1'b1;
        func3 = fm;
        ref3  = rm;
        @(posedge clk);
        #1;
        for (int i = 0; i < pat.size(); i++) begin
            if (i == abort_row) begin
                rst   = 1'b1;
                ready = 1'b1;
                start = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b0;
                exp_rows.delete();
                exp_done.delete();
                last_ones = 0;
                last_errs = 0;
                check_zero("mid_run_reset");
                return;
            end
            ready = pat[i];
            // start and mask changes during RUN must be ignored
            start = 1'($urandom_range(0, 1));
            func3 = 8'($urandom);
            ref3  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        ready = 1'($urandom_range(0, 1));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        int dd1;
        int dd8;
        int o1;
        int o8;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("reset_state");

        run(8'hF4, 8'hF4, 0, -1);
        idle(2);
        check_hold("idle_hold_1");

        run(8'hF4, 8'hF6, 0, -1);
        idle(1);
        check_hold("idle_hold_2");

        run(8'hF4, 8'hF4, 1, -1);
        idle(1);

        run(8'hF4, 8'hF4, 0, 4);
        run(8'hFF, 8'h00, 0, -1);
        idle(2);
        check_hold("full_scale_hold");

        // back-to-back restart from the DONE cycle
        run(8'hF4, 8'hF4, 2, -1);
        run(8'h01, 8'($urandom), 0, -1);
        idle(2);

        for (int t = 0; t < 20; t++) begin
            run(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), -1);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
        idle(2);
        check_hold("idle_hold_random");

        // parameter sweep: N_IN=1 and N_IN=8, all-ones functions
        f1 = '1;
        r1 = '1;
        f8 = '1;
        r8 = '1;
        s_start = 1'b1;
        @(posedge clk);
        #1;
        k = edge_cnt;
        s_start = 1'b0;
        dd1 = -1;
        dd8 = -1;
        o1 = 0;
        o8 = 0;
        for (int i = 0; i < 300 && (dd1 < 0 || dd8 < 0); i++) begin
            @(negedge clk);
            if (d1 && dd1 < 0) begin
                dd1 = edge_cnt - k + 1;
                o1  = int'(ones1);
            end
            if (d8 && dd8 < 0) begin
                dd8 = edge_cnt - k + 1;
                o8  = int'(ones8);
            end
        end
        total++;
        if (dd1 != 3 || o1 != 2) begin
            bad++;
            $display("FAIL sweep_n1: got latency=%0d ones=%0d, expected latency=3 ones=2", dd1, o1);
        end
        total++;
        if (dd8 != 257 || o8 != 256) begin
            bad++;
            $display("FAIL sweep_n8: got latency=%0d ones=%0d, expected latency=257 ones=256", dd8, o8);
        end

        idle(2);
        total++;
        if (exp_rows.size() != 0 || exp_done.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d rows and %0d done records pending, expected 0 and 0",
                     exp_rows.size(), exp_done.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_sweep.md
# tt_sweep

Parametrised, sequential truth-table engine. It latches an N_IN-input Boolean function as a 2^N_IN-bit minterm mask, together with an expected mask. It then streams every input row in ascending order over a valid/ready handshake, reporting each row's output and whether it matches the expected value. On completion it pulses done with the final ones-count and mismatch-count. It is the registered, generalised successor to our fixed 3-input combinational expression blocks, and is used both as a self-checking function evaluator and as a row-stream source for display/compare logic.

## Interface
- N_IN, default 3, number of function inputs (legal 1..8); ROWS = 2^N_IN.
- in_clk  input  1  clock; all state changes on rising edge.
- in_rst  input  1  synchronous, active-high reset.
- in_start  input  1  start request; sampled only in IDLE or DONE.
- in_func  input  ROWS  function mask; bit r = Y for row r (row bit N_IN-1 = first input, bit 0 = last). Latched on accepted start.
- in_ref  input  ROWS  expected mask, same encoding, latched with in_func.
- in_ready  input  1  downstream accepts the current row.
- out_valid  output  1  row data valid.
- out_row  output  N_IN  current row index.
- out_y  output  1  func_q[out_row].
- out_mis  output  1  func_q[out_row] XOR ref_q[out_row].
- out_busy  output  1  high in RUN.
- out_done  output  1  one-cycle pulse in DONE.
- out_ones  output  N_IN+1  running/final count of accepted rows with Y=1.
- out_errs  output  N_IN+1  running/final count of accepted rows with mismatch.

## Operation
- States: IDLE, RUN, DONE. Encoding is free, but all outputs must come from registers or from registered state via decode. There is no combinational path from any input to any output.
- IDLE:
  - out_valid=0, out_busy=0, out_done=0.
  - out_ones and out_errs hold their last values.
  - in_start=1: latch func_q<=in_func and ref_q<=in_ref; row<=0; ones<=0; errs<=0; go to RUN.
- RUN:
  - out_valid=1, out_busy=1.
  - out_row=row; out_y and out_mis are decoded from the latched masks.
  - Transfer occurs when out_valid & in_ready at a rising edge. On transfer: ones+=out_y, errs+=out_mis.
  - After a transfer, if row==ROWS-1 go to DONE; otherwise row<=row+1.
  - in_ready=0: row, out_y, out_mis and the counts hold stable.
  - in_start is ignored. in_func and in_ref changes have no effect.
- DONE:
  - Lasts exactly one cycle. out_done=1, out_valid=0, out_busy=0.
  - out_ones and out_errs are final, including the last row.
  - in_start=1 in DONE is accepted exactly as in IDLE, giving a back-to-back restart; otherwise go to IDLE.
- Count width N_IN+1 allows a maximum of ROWS without wrap. The row counter never wraps, because the exit is taken at ROWS-1.

## Timing
- Reset (in_rst=1 at an edge, in any state, including mid-RUN):
  - Next state is IDLE.
  - out_valid=0, out_busy=0, out_done=0, out_row=0, out_y=0, out_mis=0, out_ones=0, out_errs=0.
  - func_q and ref_q are cleared to 0.
- Reset has priority over start and over transfer in the same cycle.
- Start accepted at edge k: out_valid=1 with row 0 from edge k onward (visible in cycle k+1).
- With in_ready held high, row r is presented in cycle k+1+r. out_done pulses in cycle k+1+ROWS. Total latency from start to done is ROWS+1 cycles.
- Each stalled cycle (in_ready=0 in RUN) delays done by exactly one cycle.
- in_ready in IDLE or DONE is ignored.

## Test plan
- N_IN=3, in_func=8'hF4, in_ref=8'hF4, in_ready=1:
  - Rows 0..7 stream out with Y = 0,0,1,0,1,1,1,1.
  - out_done pulses 9 cycles after the start edge, with out_ones=5 and out_errs=0.
- N_IN=3, in_func=8'hF4, in_ref=8'hF6, in_ready=1:
  - out_mis=1 only on row 1.
  - Final out_errs=1, out_ones=5.
- Backpressure: same stimulus as the first scenario, with in_ready toggling 1,0,0,1,...:
  - out_row, out_y and out_mis stay stable while in_ready=0.
  - Each row is transferred exactly once; done is delayed by the number of stall cycles; final counts are unchanged (ones=5).
- Reset mid-RUN at row 4:
  - Next cycle all outputs are 0 and the state is IDLE.
  - A new start with in_func=8'hFF, in_ref=8'h00 ends with ones=8, errs=8 (full-scale count, no wrap).
- Back-to-back restart and ignored start:
  - Pulse in_start during RUN: it has no effect, and row advances normally.
  - Assert in_start in the DONE cycle with in_func=8'h01: RUN restarts at row 0 the next cycle with no IDLE gap, and ends with ones=1.
- Parameter sweep, N_IN=1 and N_IN=8 with in_func all-ones:
  - done arrives at 3 and 257 cycles respectively.
  - out_ones is 2 and 256 respectively.
